hwpe_stream_tcdm_responder: RTL and testbench
=============================================

# hwpe_stream_tcdm_responder

Slave-side endpoint of the `hwpe_stream_intf_tcdm` protocol: a single-port, word-organised scratchpad that grants TCDM requests and returns read data exactly one cycle after a granted read. It sits behind HWPE streamer masters in block-level benches and small subsystems. It provides LFSR-driven grant throttling to exercise master back-pressure, plus sticky error and access-count observability.

## Interface
- `NB_WORDS`, default 256: memory depth in 32-bit words; must be a power of two, at least 2.
- `CNT_WIDTH`, default 16: width of the access counters.
- `clk_i` in, 1: clock. Also drives `tcdm.clk`.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `clear_i` in, 1: synchronous clear of counters, `err_o`, LFSR and response register; memory contents untouched.
- `stall_en_i` in, 1: enables random grant throttling.
- `stall_mask_i` in, 4: selects the LFSR bits that cause a stall; 0 means never stall.
- `tcdm` slave modport, `hwpe_stream_intf_tcdm.slave`: the `req`, `add`, `we_n`, `be`, `data` inputs and the `gnt`, `r_data`, `r_valid` outputs.
- `err_o` out, 1: sticky flag for any granted misaligned or out-of-range access.
- `rd_cnt_o` out, CNT_WIDTH: saturating count of granted reads.
- `wr_cnt_o` out, CNT_WIDTH: saturating count of granted writes.

## Operation
- AW = $clog2(NB_WORDS). The word index is `add[AW+1:2]`.
  - An access is out-of-range if any bit of `add[31:AW+2]` is set.
  - An access is misaligned if `add[1:0]` != 0.
- Stall term: `stall = stall_en_i & |(lfsr[3:0] & stall_mask_i)`.
- Grant: `gnt = req & ~stall & ~clear_i`. This is combinational, with no dependency on `gnt` itself.
- LFSR:
  - 16-bit Galois, taps 16'hB400, seed 16'hACE1.
  - Advances every cycle while `stall_en_i`=1; otherwise holds.
  - Reloads the seed on reset or `clear_i`.
- Granted read (`we_n`=1):
  - In-range: the next cycle drives `r_valid`=1 and `r_data`=mem[index].
  - Out-of-range: the next cycle drives `r_valid`=1 and `r_data`=32'h0, and sets `err_o`.
- Granted write (`we_n`=0):
  - Writes byte lane i (`data[8i+7:8i]`) where `be[i]`=1.
  - Out-of-range writes are dropped and set `err_o`.
  - The next cycle drives `r_valid`=1 and `r_data` holds its previous value.
- Misaligned accesses use the truncated index and also set `err_o`.
- Counters increment on the granted request, saturate at all-ones, and never wrap.
- Memory is not reset. A read of an unwritten word returns X in simulation.

## Timing
- Reset values: `r_valid`=0, `r_data`=0, `err_o`=0, `rd_cnt_o`=0, `wr_cnt_o`=0, LFSR=16'hACE1.
  - `gnt` is 0 while in reset, because `req` is ignored.
- Read latency: exactly 1 cycle from the `req`&`gnt` edge to `r_valid`. No queueing; back-to-back grants give back-to-back `r_valid`.
- Read-after-write to the same word in consecutive cycles returns the newly written data. The write commits at the edge, before the read samples.
- A request held while stalled is granted on the first cycle the stall term is 0. The master must keep `add`/`data`/`be`/`we_n` stable until then.
- `clear_i` concurrent with `req`: `gnt`=0 that cycle, and `r_valid` is 0 the next cycle.
- Reset asserted mid-transaction: `r_valid` drops immediately (asynchronously) and the pending response is lost.
- Counter saturation and `err_o` set in the same cycle as `clear_i`: clear wins.

## Structure
- `hwpe_stream_package`:
  - add `HWPE_TCDM_LFSR_SEED` (16'hACE1) and `HWPE_TCDM_LFSR_TAPS` (16'hB400);
  - add a `tcdm_resp_t` struct (`r_valid`, `r_data`) for the response register.
- Sub-module `hwpe_stream_tcdm_stall_lfsr`:
  - ports `clk_i`, `rst_ni`, `clear_i`, `en_i`, `lfsr_o[15:0]`;
  - reused by future stream back-pressure injectors.
- Memory is an inferred flop/latch array inside the top; no SRAM macro.

## Test plan
- Reset, then write 32'hCAFEBABE at `add`=0x10 with `be`=4'hF, then read 0x10 → `gnt`=1 on both; read `r_valid`=1 one cycle later with `r_data`=32'hCAFEBABE; `wr_cnt_o`=1, `rd_cnt_o`=1.
- Partial write `be`=4'b0101, `data`=32'h11223344 over a word holding 32'hAAAAAAAA → read returns 32'hAA22AA44.
- `stall_en_i`=1, `stall_mask_i`=4'hF, 200 reads with `req` held → every granted read has `r_valid` the next cycle; the number of `gnt` cycles matches the reference LFSR model from seed 16'hACE1; with `stall_mask_i`=0, `gnt`=`req` every cycle.
- Read `add`=0x400 with NB_WORDS=256 → `r_data`=0, `err_o`=1 and stays 1; `clear_i` pulse → `err_o`=0, counters 0.
- Write then immediate read of the same word on consecutive cycles → new data returned; assert `rst_ni`=0 during the read's response cycle → `r_valid` drops immediately.
- CNT_WIDTH=4 with 20 granted reads → `rd_cnt_o` stays at 4'hF.

Source files
------------

// File: rtl/hwpe_stream_tcdm_responder_pkg.sv
// Shared constants and types for the TCDM responder and its stall-injection LFSR.
package hwpe_stream_package;

  localparam logic [15:0] HWPE_TCDM_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] HWPE_TCDM_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        r_valid;
    logic [31:0] r_data;
  } tcdm_resp_t;

endpackage

// File: rtl/hwpe_stream_tcdm_responder_if.sv
// TCDM request/response bundle between a streamer master and a memory-side slave.
interface hwpe_stream_intf_tcdm (
  input logic clk
);

  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        we_n;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    input  clk,
    output req, add, we_n, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, we_n, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/hwpe_stream_tcdm_responder_stall_lfsr.sv
// 16-bit Galois LFSR used as a pseudo-random source for back-pressure injection.
module hwpe_stream_tcdm_stall_lfsr
  import hwpe_stream_package::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_o[15:1]};
    if (lfsr_o[0]) lfsr_d = lfsr_d ^ HWPE_TCDM_LFSR_TAPS;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_o <= HWPE_TCDM_LFSR_SEED;
    end else if (clear_i) begin
      lfsr_o <= HWPE_TCDM_LFSR_SEED;
    end else if (en_i) begin
      lfsr_o <= lfsr_d;
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// Single-port word scratchpad answering TCDM requests with 1-cycle read latency,
// optional random grant throttling, sticky error flag and saturating access counters.
module hwpe_stream_tcdm_responder
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_WORDS  = 256,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 stall_en_i,
  input  logic [3:0]           stall_mask_i,
  hwpe_stream_intf_tcdm.slave  tcdm,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic [CNT_WIDTH-1:0] wr_cnt_o
);

  localparam int unsigned AW = $clog2(NB_WORDS);

  logic [15:0]          lfsr;
  logic                 stall;
  logic                 gnt;
  logic                 rd_gnt;
  logic                 wr_gnt;
  logic                 oor;
  logic                 misal;
  logic [AW-1:0]        idx;
  tcdm_resp_t           resp_q;
  logic                 err_q;
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;
  logic [31:0]          mem_q [NB_WORDS];

  hwpe_stream_tcdm_stall_lfsr i_stall_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (stall_en_i),
    .lfsr_o  (lfsr)
  );

  assign idx   = tcdm.add[AW+1:2];
  assign oor   = |tcdm.add[31:AW+2];
  assign misal = |tcdm.add[1:0];
  assign stall = stall_en_i & |(lfsr[3:0] & stall_mask_i);

  // rst_ni gates the grant so a request seen during reset is never acknowledged.
  assign gnt    = tcdm.req & ~stall & ~clear_i & rst_ni;
  assign rd_gnt = gnt &  tcdm.we_n;
  assign wr_gnt = gnt & ~tcdm.we_n;

  always_ff @(posedge clk_i) begin
    if (wr_gnt && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (tcdm.be[i]) mem_q[idx][8*i +: 8] <= tcdm.data[8*i +: 8];
      end
    end
  end

  // Write responses keep r_data unchanged; only reads update it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else if (clear_i) begin
      resp_q <= '0;
    end else begin
      resp_q.r_valid <= gnt;
      if (rd_gnt) resp_q.r_data <= oor ? 32'h0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (clear_i) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (gnt && (oor || misal)) err_q <= 1'b1;
      if (rd_gnt && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
      if (wr_gnt && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign tcdm.gnt     = gnt;
  assign tcdm.r_valid = resp_q.r_valid;
  assign tcdm.r_data  = resp_q.r_data;
  assign err_o        = err_q;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Directed bench for the TCDM responder with a cycle-level reference model of the memory.
module tb_hwpe_stream_tcdm_responder;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        stall_en = 1'b0;
  logic [3:0]  stall_mask = 4'h0;
  logic        err, err4;
  logic [15:0] rd_cnt, wr_cnt;
  logic [3:0]  rd_cnt4, wr_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_tcdm tcdm  (.clk(clk));
  hwpe_stream_intf_tcdm tcdm4 (.clk(clk));

  hwpe_stream_tcdm_responder #(.NB_WORDS(256), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_en_i(stall_en),
    .stall_mask_i(stall_mask), .tcdm(tcdm), .err_o(err),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  hwpe_stream_tcdm_responder #(.NB_WORDS(256), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_en_i(stall_en),
    .stall_mask_i(stall_mask), .tcdm(tcdm4), .err_o(err4),
    .rd_cnt_o(rd_cnt4), .wr_cnt_o(wr_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic we_n, input logic [31:0] add,
                       input logic [3:0] be, input logic [31:0] data);
    tcdm.req  = req;  tcdm.we_n  = we_n; tcdm.add  = add; tcdm.be  = be; tcdm.data  = data;
    tcdm4.req = req;  tcdm4.we_n = we_n; tcdm4.add = add; tcdm4.be = be; tcdm4.data = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: state here is what the DUT registers hold after the coming edge.
  logic [31:0] m_mem [256];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_rd, m_wr, m_rd4, m_wr4;
  logic [15:0] m_lfsr;
  bit          counting = 0;
  int          gnt_cnt_model = 0;
  int          gnt_cnt_dut = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 'x;
  end

  always @(negedge clk) begin
    logic        exp_gnt;
    logic [31:0] a;
    int          w;
    bit          oor;
    if (!rst_n) begin
      m_rvalid = 0; m_rdata = 0; m_err = 0;
      m_rd = 0; m_wr = 0; m_rd4 = 0; m_wr4 = 0; m_lfsr = SEED;
      chk("rst_gnt", {31'h0, tcdm.gnt}, 32'h0);
      chk("rst_rvalid", {31'h0, tcdm.r_valid}, 32'h0);
      chk("rst_rdata", tcdm.r_data, 32'h0);
      chk("rst_cnt", {rd_cnt, wr_cnt}, 32'h0);
    end else begin
      exp_gnt = tcdm.req && !clear && !(stall_en && ((m_lfsr[3:0] & stall_mask) != 4'h0));
      chk("gnt", {31'h0, tcdm.gnt}, {31'h0, exp_gnt});
      chk("gnt4", {31'h0, tcdm4.gnt}, {31'h0, exp_gnt});
      chk("r_valid", {31'h0, tcdm.r_valid}, {31'h0, m_rvalid});
      chk("r_data", tcdm.r_data, m_rdata);
      chk("err", {31'h0, err}, {31'h0, m_err});
      chk("rd_cnt", {16'h0, rd_cnt}, m_rd);
      chk("wr_cnt", {16'h0, wr_cnt}, m_wr);
      chk("rd_cnt4", {28'h0, rd_cnt4}, m_rd4);
      chk("wr_cnt4", {28'h0, wr_cnt4}, m_wr4);
      if (counting) begin
        gnt_cnt_model += int'(exp_gnt);
        gnt_cnt_dut   += int'(tcdm.gnt);
      end
      if (clear) begin
        m_rvalid = 0; m_rdata = 0; m_err = 0;
        m_rd = 0; m_wr = 0; m_rd4 = 0; m_wr4 = 0; m_lfsr = SEED;
      end else begin
        if (stall_en) m_lfsr = lfsr_next(m_lfsr);
        m_rvalid = exp_gnt;
        if (exp_gnt) begin
          a   = tcdm.add;
          w   = int'(a[9:2]);
          oor = (a >= 32'h400);
          if (oor || a[1:0] != 2'b00) m_err = 1;
          if (tcdm.we_n) begin
            m_rdata = oor ? 32'h0 : m_mem[w];
            m_rd  = (m_rd  < 65535) ? m_rd  + 1 : m_rd;
            m_rd4 = (m_rd4 < 15)    ? m_rd4 + 1 : m_rd4;
          end else begin
            if (!oor)
              for (int b = 0; b < 4; b++)
                if (tcdm.be[b]) m_mem[w][8*b +: 8] = tcdm.data[8*b +: 8];
            m_wr  = (m_wr  < 65535) ? m_wr  + 1 : m_wr;
            m_wr4 = (m_wr4 < 15)    ? m_wr4 + 1 : m_wr4;
          end
        end
      end
    end
  end

  initial begin
    idle();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // full write then read back
    drive(1, 0, 32'h10, 4'hF, 32'hCAFEBABE); step();
    drive(1, 1, 32'h10, 4'h0, 32'h0);        step();
    idle();
    chk("rd_basic_valid", {31'h0, tcdm.r_valid}, 32'h1);
    chk("rd_basic_data", tcdm.r_data, 32'hCAFEBABE);
    chk("rd_basic_cnts", {rd_cnt, wr_cnt}, {16'd1, 16'd1});

    // partial byte-enable write
    drive(1, 0, 32'h20, 4'hF, 32'hAAAAAAAA); step();
    drive(1, 0, 32'h20, 4'h5, 32'h11223344); step();
    drive(1, 1, 32'h20, 4'h0, 32'h0);        step();
    idle();
    chk("partial_wr", tcdm.r_data, 32'hAA22AA44);

    // out-of-range read and sticky error
    drive(1, 1, 32'h400, 4'h0, 32'h0); step();
    idle();
    chk("oor_rdata", tcdm.r_data, 32'h0);
    chk("oor_err", {31'h0, err}, 32'h1);
    repeat (3) step();
    chk("err_sticky", {31'h0, err}, 32'h1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_err", {31'h0, err}, 32'h0);
    chk("clear_cnts", {rd_cnt, wr_cnt}, 32'h0);

    // clear concurrent with a request: no grant, no response
    clear = 1'b1; drive(1, 1, 32'h10, 4'h0, 32'h0); step();
    clear = 1'b0; idle();
    chk("clear_req_rvalid", {31'h0, tcdm.r_valid}, 32'h0);

    // misaligned read uses the truncated index
    drive(1, 1, 32'h13, 4'h0, 32'h0); step();
    idle();
    chk("misal_data", tcdm.r_data, 32'hCAFEBABE);
    chk("misal_err", {31'h0, err}, 32'h1);
    clear = 1'b1; step(); clear = 1'b0;

    // out-of-range write is dropped and does not alias onto word 4
    drive(1, 0, 32'h410, 4'hF, 32'hDEADBEEF); step();
    drive(1, 1, 32'h10, 4'h0, 32'h0);         step();
    idle();
    chk("oor_wr_dropped", tcdm.r_data, 32'hCAFEBABE);
    chk("oor_wr_err", {31'h0, err}, 32'h1);
    step();

    // read-after-write then reset during the response cycle
    drive(1, 0, 32'h30, 4'hF, 32'h12345678); step();
    drive(1, 1, 32'h30, 4'h0, 32'h0);        step();
    idle();
    chk("raw_data", tcdm.r_data, 32'h12345678);
    chk("raw_valid", {31'h0, tcdm.r_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_rvalid", {31'h0, tcdm.r_valid}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // random throttling with a held read request
    stall_en = 1'b1; stall_mask = 4'hF; counting = 1;
    drive(1, 1, 32'h30, 4'h0, 32'h0);
    #1 chk("stall_first_gnt", {31'h0, tcdm.gnt}, 32'h0);
    step();
    chk("lfsr_model_pin", {16'h0, m_lfsr}, 32'h0000E270);
    chk("stall_second_gnt", {31'h0, tcdm.gnt}, 32'h1);
    repeat (199) step();
    counting = 0;
    chk("stall_gnt_count", gnt_cnt_dut, gnt_cnt_model);
    stall_mask = 4'h0;
    repeat (10) step();
    chk("mask0_gnt", {31'h0, tcdm.gnt}, 32'h1);
    idle(); stall_en = 1'b0;
    step(); step();
    chk("rd_cnt4_sat", {28'h0, rd_cnt4}, 32'hF);
    chk("data_after_stall", tcdm.r_data, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
